// File: rtl/stochastic_computing_lfsr_scheduler_pkg.sv
// Shared types and constants for the stochastic-computing LFSR scheduler.
// Holds the scheduler state encoding and the Galois feedback masks used by
// the LFSR sub-module (maximal-length polynomials for widths 2..23).
`timescale 1ns/1ps
package stochastic_computing_lfsr_scheduler_pkg;

  // state  | meaning
  // INIT   | load SEED into the LFSR after reset, outputs idle, busy
  // SERVE  | arbitrate requests, hand out one LFSR word per grant
  // RESEED | load the captured seed into the LFSR, busy
  typedef enum logic [1:0] {
    INIT   = 2'd0,
    SERVE  = 2'd1,
    RESEED = 2'd2
  } state_t;

  localparam int MAX_SIZE = 23;

  // Right-shift Galois feedback mask for a maximal-length sequence.
  function automatic logic [MAX_SIZE-1:0] galois_taps(input int size);
    logic [MAX_SIZE-1:0] taps;
    case (size)
      2:       taps = 23'h000003;
      3:       taps = 23'h000006;
      4:       taps = 23'h00000C;
      5:       taps = 23'h000014;
      6:       taps = 23'h000030;
      7:       taps = 23'h000060;
      8:       taps = 23'h0000B8;
      9:       taps = 23'h000110;
      10:      taps = 23'h000240;
      11:      taps = 23'h000500;
      12:      taps = 23'h000829;
      13:      taps = 23'h00100D;
      14:      taps = 23'h002015;
      15:      taps = 23'h006000;
      16:      taps = 23'h00D008;
      17:      taps = 23'h012000;
      18:      taps = 23'h020400;
      19:      taps = 23'h040023;
      20:      taps = 23'h090000;
      21:      taps = 23'h140000;
      22:      taps = 23'h300000;
      default: taps = 23'h420000;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/stochastic_computing_lfsr_scheduler_galois.sv
// Galois LFSR, right-shifting, SIZE bits. i_set loads i_setval and takes
// priority over i_en; i_en advances one step. The value comes out of reset
// as 1 so it is never zero even before the first load.
`timescale 1ns/1ps
module stochastic_computing_lfsr_galois
  import stochastic_computing_lfsr_scheduler_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_en,
  input  logic            i_set,
  input  logic [SIZE-1:0] i_setval,
  output logic [SIZE-1:0] o_val
);

  localparam logic [MAX_SIZE-1:0] TAPS_FULL = galois_taps(SIZE);
  localparam logic [SIZE-1:0]     TAPS      = TAPS_FULL[SIZE-1:0];

  // Load, step, or hold the shift register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_val <= SIZE'(1);
    end else if (i_set) begin
      o_val <= i_setval;
    end else if (i_en) begin
      o_val <= o_val[0] ? ((o_val >> 1) ^ TAPS) : (o_val >> 1);
    end
  end

endmodule

// File: rtl/stochastic_computing_lfsr_scheduler.sv
// Round-robin scheduler handing out words of a shared Galois LFSR.
// One requester is granted per cycle; the granted requester consumes o_val
// and the LFSR steps at that edge. A reseed request takes priority over
// grants. Optional feature: define STOCHASTIC_COMPUTING_LFSR_SCHEDULER_PERIOD_EN
// to count grants and pulse o_wrap on the last word of each LFSR period.
`timescale 1ns/1ps
module stochastic_computing_lfsr_scheduler
  import stochastic_computing_lfsr_scheduler_pkg::*;
#(
  parameter int          SIZE    = 8,
  parameter int          NUM_REQ = 4,
  parameter int unsigned SEED    = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [SIZE-1:0]    o_val,
  output logic               o_valid,
  input  logic               i_reseed,
  input  logic [SIZE-1:0]    i_seed,
  output logic               o_busy,
  output logic               o_wrap
);

  localparam int              IDX_W  = $clog2(NUM_REQ);
  localparam logic [SIZE-1:0] SEED_W = SIZE'(SEED);

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [SIZE-1:0]    seed_q;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;
  logic               grant_fire;
  logic               lfsr_set;
  logic [SIZE-1:0]    lfsr_setval;
  int                 cand;

  // Round-robin search starting just after the last granted index.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (!pick_found && i_req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

  assign grant_fire  = (state == SERVE) && !i_reseed && pick_found;
  assign o_gnt       = grant_fire ? (NUM_REQ'(1) << pick_idx) : '0;
  assign o_valid     = grant_fire;
  assign o_busy      = (state != SERVE);
  assign lfsr_set    = (state == INIT) || (state == RESEED);
  assign lfsr_setval = (state == INIT) ? SEED_W : seed_q;

  // Sequencer: INIT/RESEED last one cycle each, SERVE tracks the pointer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= INIT;
      ptr    <= IDX_W'(NUM_REQ - 1);
      seed_q <= SEED_W;
    end else begin
      case (state)
        INIT: begin
          state <= SERVE;
        end
        SERVE: begin
          if (i_reseed) begin
            state  <= RESEED;
            seed_q <= (i_seed == '0) ? SEED_W : i_seed;
          end else if (grant_fire) begin
            ptr <= pick_idx;
          end
        end
        RESEED: begin
          state <= SERVE;
        end
        default: begin
          state <= INIT;
        end
      endcase
    end
  end

  stochastic_computing_lfsr_galois #(
    .SIZE (SIZE)
  ) u_lfsr (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_en     (grant_fire),
    .i_set    (lfsr_set),
    .i_setval (lfsr_setval),
    .o_val    (o_val)
  );

`ifdef STOCHASTIC_COMPUTING_LFSR_SCHEDULER_PERIOD_EN
  // Grant number 2^SIZE-1 after a (re)seed is the last word of the period.
  localparam logic [SIZE-1:0] WRAP_AT = SIZE'((1 << SIZE) - 2);

  logic [SIZE-1:0] grant_cnt;

  // Count grants since the last (re)seed; clear on wrap or on any seed load.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      grant_cnt <= '0;
    end else if (state != SERVE || i_reseed) begin
      grant_cnt <= '0;
    end else if (grant_fire) begin
      grant_cnt <= (grant_cnt == WRAP_AT) ? '0 : grant_cnt + SIZE'(1);
    end
  end

  assign o_wrap = grant_fire && (grant_cnt == WRAP_AT);
`else
  assign o_wrap = 1'b0;
`endif

endmodule

// File: tb/tb_stochastic_computing_lfsr_scheduler.sv
// Scoreboard bench: stimulus pushes the expected grant/value/wrap for each
// grant cycle; a monitor pops and compares whenever o_valid is high.
// LFSR words are a hand-computed table for SIZE=4, taps x^4+x^3+1, seed 1.
`timescale 1ns/1ps
module tb_stochastic_computing_lfsr_scheduler;

  localparam int          SIZE    = 4;
  localparam int          NUM_REQ = 4;
  localparam int unsigned SEED    = 1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NUM_REQ-1:0] req = '0;
  logic               reseed = 1'b0;
  logic [SIZE-1:0]    seed = '0;
  logic [NUM_REQ-1:0] o_gnt;
  logic [SIZE-1:0]    o_val;
  logic               o_valid;
  logic               o_busy;
  logic               o_wrap;

  stochastic_computing_lfsr_scheduler #(
    .SIZE    (SIZE),
    .NUM_REQ (NUM_REQ),
    .SEED    (SEED)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_req    (req),
    .o_gnt    (o_gnt),
    .o_val    (o_val),
    .o_valid  (o_valid),
    .i_reseed (reseed),
    .i_seed   (seed),
    .o_busy   (o_busy),
    .o_wrap   (o_wrap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] gnt;
    logic [3:0] val;
    logic       wrap;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   idx = 0;
  int   gcount = 0;

  logic [3:0] seq [0:14] = '{4'h1, 4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE,
                             4'h7, 4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic seeded(input int start_idx);
    idx    = start_idx;
    gcount = 0;
  endtask

  task automatic push_grant(input logic [3:0] gnt);
    exp_t e;
    gcount++;
    e.gnt = gnt;
    e.val = seq[idx];
    idx   = (idx + 1) % 15;
`ifdef STOCHASTIC_COMPUTING_LFSR_SCHEDULER_PERIOD_EN
    e.wrap = (gcount == 15);
    if (gcount == 15) gcount = 0;
`else
    e.wrap = 1'b0;
`endif
    q.push_back(e);
  endtask

  task automatic step_grant(input logic [3:0] r, input logic [3:0] g);
    @(posedge clk);
    #1;
    req = r;
    push_grant(g);
    @(negedge clk);
  endtask

  task automatic step_idle();
    @(posedge clk);
    #1;
    req = '0;
    @(negedge clk);
    check("idle_valid", 32'(o_valid), 32'd0);
    check("idle_gnt", 32'(o_gnt), 32'd0);
  endtask

  // Monitor: every presented grant must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (o_valid) begin
      n_vec++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_grant actual gnt=%b val=%h wrap=%b required no grant",
                 o_gnt, o_val, o_wrap);
      end else begin
        e = q.pop_front();
        if (o_gnt !== e.gnt || o_val !== e.val || o_wrap !== e.wrap) begin
          n_bad++;
          $display("FAIL grant actual gnt=%b val=%h wrap=%b required gnt=%b val=%h wrap=%b",
                   o_gnt, o_val, o_wrap, e.gnt, e.val, e.wrap);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // reset state with a request already present
    req = 4'b0001;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(o_busy), 32'd1);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_gnt", 32'(o_gnt), 32'd0);
    check("rst_wrap", 32'(o_wrap), 32'd0);

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seeded(0);
    @(negedge clk);
    check("init_busy", 32'(o_busy), 32'd1);
    check("init_valid", 32'(o_valid), 32'd0);

    // two full periods from a single requester
    for (int k = 0; k < 30; k++) step_grant(4'b0001, 4'b0001);
    check("serve_busy", 32'(o_busy), 32'd0);

    // all requesting, pointer resumes after index 0
    step_grant(4'b1111, 4'b0010);
    step_grant(4'b1111, 4'b0100);
    step_grant(4'b1111, 4'b1000);
    step_grant(4'b1111, 4'b0001);
    step_grant(4'b1111, 4'b0010);

    // sparse requests alternate
    step_grant(4'b1010, 4'b1000);
    step_grant(4'b1010, 4'b0010);
    step_grant(4'b1010, 4'b1000);
    step_grant(4'b1010, 4'b0010);

    step_idle();
    step_idle();

    // reseed to 5; a second reseed during RESEED is ignored
    @(posedge clk);
    #1;
    req    = 4'b1111;
    reseed = 1'b1;
    seed   = 4'd5;
    @(negedge clk);
    check("rs_valid", 32'(o_valid), 32'd0);
    @(posedge clk);
    #1;
    seed = 4'd9;
    @(negedge clk);
    check("rs_busy", 32'(o_busy), 32'd1);
    check("rs_hold_valid", 32'(o_valid), 32'd0);
    @(posedge clk);
    #1;
    reseed = 1'b0;
    seeded(6);
    push_grant(4'b0100);
    @(negedge clk);
    step_grant(4'b1111, 4'b1000);

    // zero seed falls back to SEED
    @(posedge clk);
    #1;
    reseed = 1'b1;
    seed   = 4'd0;
    @(negedge clk);
    check("zs_valid", 32'(o_valid), 32'd0);
    @(posedge clk);
    #1;
    reseed = 1'b0;
    @(negedge clk);
    check("zs_busy", 32'(o_busy), 32'd1);
    seeded(0);
    step_grant(4'b1111, 4'b0001);
    step_grant(4'b1111, 4'b0010);

    // reset mid-cycle while granting
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mr_valid", 32'(o_valid), 32'd0);
    check("mr_gnt", 32'(o_gnt), 32'd0);
    check("mr_busy", 32'(o_busy), 32'd1);
    check("mr_wrap", 32'(o_wrap), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seeded(0);
    @(negedge clk);
    check("mr_init_busy", 32'(o_busy), 32'd1);
    step_grant(4'b1111, 4'b0001);
    step_grant(4'b1111, 4'b0010);
    step_grant(4'b1111, 4'b0100);
    step_grant(4'b1111, 4'b1000);
    step_grant(4'b1111, 4'b0001);

    @(posedge clk);
    #1;
    req = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/stochastic_computing_lfsr_scheduler.md
STOCHASTIC_COMPUTING_LFSR_SCHEDULER -- requirements
Module: stochastic_computing_lfsr_scheduler

Interface
REQ-001 The block SHALL have parameter SIZE, default 8, giving the LFSR width in bits (legal range 2..23).
REQ-002 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters (legal range 2..16).
REQ-003 The block SHALL have parameter SEED, default 1, giving the non-zero seed loaded after reset.
REQ-004 Port i_clk SHALL be an input, 1 bit wide, serving as the single clock (rising edge).
REQ-005 Port i_rst_n SHALL be an input, 1 bit wide, serving as the asynchronous active-low reset.
REQ-006 Port i_req SHALL be an input, NUM_REQ bits wide, carrying per-requester requests for one random word.
REQ-007 Port o_gnt SHALL be an output, NUM_REQ bits wide, carrying the one-hot grant, valid in the same cycle as o_val.
REQ-008 Port o_val SHALL be an output, SIZE bits wide, carrying the current LFSR word; the granted requester consumes it.
REQ-009 Port o_valid SHALL be an output, 1 bit wide, and SHALL be high when any o_gnt bit is high.
REQ-010 Port i_reseed SHALL be an input, 1 bit wide, carrying a single-cycle reseed request.
REQ-011 Port i_seed SHALL be an input, SIZE bits wide, carrying the seed value sampled while i_reseed=1.
REQ-012 Port o_busy SHALL be an output, 1 bit wide, and SHALL be high in INIT and RESEED.
REQ-013 Port o_wrap SHALL be an output, 1 bit wide, carrying a one-cycle pulse at LFSR period completion (see Configuration).

Function
REQ-014 The FSM SHALL have three states: INIT, SERVE and RESEED.
REQ-015 INIT SHALL drive LFSR i_set=1 and i_setval=SEED for exactly one cycle, then go to SERVE.
REQ-016 In SERVE with i_reseed=1, the FSM SHALL go to RESEED; the seed (i_seed, or SEED if i_seed==0) SHALL be captured; no grant SHALL be issued that cycle, because reseed has priority.
REQ-017 RESEED SHALL drive i_set=1 with the captured seed for one cycle, then go to SERVE.
REQ-018 In SERVE with no i_reseed and |i_req, exactly one o_gnt bit SHALL be set, and LFSR i_en=1 SHALL advance the LFSR at that clock edge.
REQ-019 Arbitration SHALL be round-robin: search starts at the index after the last granted index, modulo NUM_REQ; the pointer SHALL reset to NUM_REQ-1 so that index 0 has first priority.
REQ-020 The pointer SHALL update only on a grant cycle.
REQ-021 With no request, the LFSR SHALL hold (i_en=0) and o_gnt SHALL be 0.
REQ-022 o_val SHALL never be 0; a zero seed SHALL be replaced by SEED.
REQ-023 i_reseed asserted in INIT or RESEED SHALL be ignored.
REQ-024 Requests SHALL be level-sensitive; a requester holding i_req receives its next grant after all other active requesters have been served.

Reset
REQ-025 On i_rst_n=0, the block SHALL asynchronously set state=INIT, o_gnt=0, o_valid=0, o_busy=1, o_wrap=0, pointer=NUM_REQ-1 and the period counter to 0.
REQ-026 Reset asserted mid-operation SHALL abort any grant or reseed, and the first grant after release SHALL return SEED.

Configuration
REQ-027 When STOCHASTIC_COMPUTING_LFSR_SCHEDULER_PERIOD_EN is defined, a SIZE-bit counter SHALL count grants.
REQ-028 With the macro defined, o_wrap SHALL pulse in the cycle of grant number 2^SIZE-1 after the last (re)seed, after which the counter SHALL clear.
REQ-029 With the macro defined, any reseed SHALL also clear the counter.
REQ-030 Without the macro, o_wrap SHALL be tied to 0 and no counter SHALL exist.

Structure
REQ-031 A shared package stochastic_computing_lfsr_scheduler_pkg SHALL hold the state enum (INIT, SERVE, RESEED).
REQ-032 The block SHALL contain exactly one sub-module, the existing stochastic_computing_lfsr_galois #(SIZE), instantiated internally and driven only by the FSM.

Verification
REQ-033 Reset test: SIZE=4, SEED=1, i_req=0001 held from reset release -> o_busy=1 for one cycle; first grant o_val=1; next 15 grants give distinct non-zero values; grant 16 o_val=1.
REQ-034 Round-robin test: NUM_REQ=4, i_req=1111 held -> o_gnt sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles.
REQ-035 Sparse-request test: i_req=1010 held -> o_gnt alternates 0010, 1000; o_valid=0 whenever i_req=0.
REQ-036 Reseed test: i_reseed=1 with i_seed=5 while i_req=1111 -> no grant that cycle and o_busy=1 for one cycle; next grant o_val=5.
REQ-037 Zero-seed and mid-reset test: i_reseed=1 with i_seed=0 -> next grant o_val=SEED; i_rst_n pulsed low mid-stream -> outputs clear immediately, and the first grant after release gives o_val=SEED with o_gnt=0001.
REQ-038 Wrap test (macro defined): SIZE=4, continuous grants -> o_wrap is high only on grant 15 and again on grant 30.
